// File: rtl/adc_emul_mc.sv
// Multichannel ADC stimulus generator: time-multiplexed per-channel waveforms on a valid/ready stream.
// One cycle from enable to first beat; outputs move only at start or transfer and hold while stalled.
module adc_emul_mc #(
  parameter int WIDTH     = 16,
  parameter int CHANNELS  = 4,
  parameter int MAX_VAL   = 2**15 - 2,
  parameter int CH_OFFSET = 1024,
  parameter int FRAME_LEN = 256,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] step,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [CW-1:0]    m_chan,
  output logic             m_last
);

  localparam int NA = 2**CW;
  localparam int AW = WIDTH + 1;
  localparam logic [AW-1:0] MAXV = AW'(MAX_VAL);

  generate
    if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
      $error("adc_emul_mc: CHANNELS must be in 1..16");
    end
    if (MAX_VAL >= (1 << WIDTH)) begin : g_bad_max
      $error("adc_emul_mc: MAX_VAL must be below 2**WIDTH");
    end
    if ((CHANNELS - 1) * CH_OFFSET > MAX_VAL) begin : g_bad_offset
      $error("adc_emul_mc: (CHANNELS-1)*CH_OFFSET exceeds MAX_VAL");
    end
  endgenerate

  typedef enum logic {S_IDLE, S_RUN} state_t;
  state_t r_state, w_state_nxt;
  logic   w_start, w_advance;

  logic [WIDTH-1:0] r_acc [NA];
  logic [NA-1:0]    r_dir;          // 1 = triangle heading down
  logic [FW-1:0]    r_set;
  logic [1:0]       r_mode;
  logic [WIDTH-1:0] r_step, r_seq, r_data;
  logic [CW-1:0]    r_chan;
  logic             r_last;

  logic             w_fire, w_dir_upd, w_last_ch, w_wrap;
  logic [WIDTH-1:0] w_cur, w_acc_upd, w_nacc, w_nseq;
  logic [AW-1:0]    w_sum;
  logic [CW-1:0]    w_nchan;
  logic [FW-1:0]    w_nset;
  logic [1:0]       w_nmode;

  function automatic logic [WIDTH-1:0] ch_base(input logic [CW-1:0] k);
    return WIDTH'(int'(k) * CH_OFFSET);
  endfunction

  function automatic logic [WIDTH-1:0] beat_val(input logic [1:0] md, input logic [CW-1:0] k,
                                                input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] s);
    case (md)
      2'd2:    beat_val = ch_base(k);
      2'd3:    beat_val = s;
      default: beat_val = a;
    endcase
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      S_IDLE: if (enable) begin
        w_state_nxt = S_RUN;
        w_start     = 1'b1;
      end
      S_RUN: if (m_ready) begin
        if (enable) w_advance = 1'b1;
        else        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_fire = (r_state == S_RUN) && m_ready;
  assign w_cur  = r_acc[r_chan];
  assign w_sum  = {1'b0, w_cur} + {1'b0, r_step};

  // A zero step freezes both value and triangle direction.
  always_comb begin
    w_acc_upd = w_cur;
    w_dir_upd = r_dir[r_chan];
    if (r_step != '0) begin
      case (r_mode)
        2'd0: begin
          if (!r_dir[r_chan]) begin
            if (w_sum >= MAXV) begin
              w_acc_upd = WIDTH'(MAX_VAL);
              w_dir_upd = 1'b1;
            end else begin
              w_acc_upd = w_sum[WIDTH-1:0];
            end
          end else if (w_cur <= r_step) begin
            w_acc_upd = '0;
            w_dir_upd = 1'b0;
          end else begin
            w_acc_upd = w_cur - r_step;
          end
        end
        2'd1: w_acc_upd = (w_sum > MAXV) ? '0 : w_sum[WIDTH-1:0];
        default: ;
      endcase
    end
  end

  assign w_last_ch = (r_chan == CW'(CHANNELS - 1));
  assign w_wrap    = w_last_ch && (r_set == FW'(FRAME_LEN - 1));
  assign w_nchan   = w_last_ch ? '0 : r_chan + 1'b1;
  assign w_nset    = w_wrap ? '0 : (w_last_ch ? r_set + 1'b1 : r_set);
  assign w_nmode   = w_wrap ? mode : r_mode;
  assign w_nseq    = r_seq + 1'b1;
  // Single-channel builds present the value just written back.
  assign w_nacc    = (w_nchan == r_chan) ? w_acc_upd : r_acc[w_nchan];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      for (int i = 0; i < NA; i++) r_acc[i] <= WIDTH'(i * CH_OFFSET);
      r_dir   <= '0;
      r_set   <= '0;
      r_mode  <= 2'd0;
      r_step  <= WIDTH'(1);
      r_seq   <= '0;
      r_data  <= '0;
      r_chan  <= '0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_fire) begin
        r_acc[r_chan] <= w_acc_upd;
        r_dir[r_chan] <= w_dir_upd;
        r_seq         <= w_nseq;
      end
      if (w_start) begin
        r_chan <= '0;
        r_set  <= '0;
        r_mode <= mode;
        r_step <= step;
        r_data <= beat_val(mode, '0, r_acc[0], r_seq);
        r_last <= (CHANNELS == 1) && (FRAME_LEN == 1);
      end else if (w_advance) begin
        r_chan <= w_nchan;
        r_set  <= w_nset;
        r_mode <= w_nmode;
        if (w_wrap) r_step <= step;
        r_data <= beat_val(w_nmode, w_nchan, w_nacc, w_nseq);
        r_last <= (w_nchan == CW'(CHANNELS - 1)) && (w_nset == FW'(FRAME_LEN - 1));
      end
    end
  end

  assign m_valid = (r_state == S_RUN);
  assign m_data  = r_data;
  assign m_chan  = r_chan;
  assign m_last  = r_last;

endmodule

// File: tb/tb_adc_emul_mc.sv
// Directed bench for adc_emul_mc: three instances cover 4-channel framing, 1-channel waveform
// vectors and an 8-bit build for triangle turns and sequence wrap.
module tb_adc_emul_mc;
  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  logic        en_a, rdy_a, vld_a, last_a;
  logic [1:0]  mode_a, ch_a;
  logic [15:0] step_a, dat_a;
  logic        en_b, rdy_b, vld_b, last_b, ch_b;
  logic [1:0]  mode_b;
  logic [15:0] step_b, dat_b;
  logic        en_c, rdy_c, vld_c, last_c, ch_c;
  logic [1:0]  mode_c;
  logic [7:0]  step_c, dat_c;

  adc_emul_mc #(.WIDTH(16), .CHANNELS(4), .MAX_VAL(32766), .CH_OFFSET(1024), .FRAME_LEN(4)) u_a (
    .clk(clk), .reset(rst_n), .enable(en_a), .mode(mode_a), .step(step_a),
    .m_valid(vld_a), .m_ready(rdy_a), .m_data(dat_a), .m_chan(ch_a), .m_last(last_a));

  adc_emul_mc #(.WIDTH(16), .CHANNELS(1), .MAX_VAL(32766), .CH_OFFSET(1024), .FRAME_LEN(1)) u_b (
    .clk(clk), .reset(rst_n), .enable(en_b), .mode(mode_b), .step(step_b),
    .m_valid(vld_b), .m_ready(rdy_b), .m_data(dat_b), .m_chan(ch_b), .m_last(last_b));

  adc_emul_mc #(.WIDTH(8), .CHANNELS(1), .MAX_VAL(10), .CH_OFFSET(0), .FRAME_LEN(1)) u_c (
    .clk(clk), .reset(rst_n), .enable(en_c), .mode(mode_c), .step(step_c),
    .m_valid(vld_c), .m_ready(rdy_c), .m_data(dat_c), .m_chan(ch_c), .m_last(last_c));

  // Four channels from 0/1024/2048/3072, step 10000, triangle until mode 1 lands at beat 16.
  int fr_exp [32] = '{0, 1024, 2048, 3072, 10000, 11024, 12048, 13072,
                      20000, 21024, 22048, 23072, 30000, 31024, 32048, 32766,
                      32766, 32766, 32766, 22766, 0, 0, 0, 32766,
                      10000, 10000, 10000, 0, 20000, 20000, 20000, 10000};
  int resume_exp [4] = '{0, 30000, 30000, 20000};
  int bt_exp [10] = '{0, 10000, 20000, 30000, 0, 20000, 32766, 12766, 0, 20000};

  logic        xfer;
  logic [15:0] p_dat;
  logic [1:0]  p_ch;
  logic        p_last;
  int exp_seq, exp_ch, exp_set, n_xfer, bad_seq, bad_stall, bad_vld, saw_wrap;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    en_a = 0; mode_a = 0; step_a = 1; rdy_a = 0;
    en_b = 0; mode_b = 0; step_b = 1; rdy_b = 0;
    en_c = 0; mode_c = 0; step_c = 1; rdy_c = 0;
    repeat (2) tick();
    chk("rst_valid", vld_a, 0);
    chk("rst_data", dat_a, 0);
    chk("rst_chan", ch_a, 0);
    chk("rst_last", last_a, 0);

    rst_n = 1'b1; en_a = 1; rdy_a = 1;
    chk("start_not_yet_valid", vld_a, 0);
    for (int j = 0; j < 8; j++) begin
      tick();
      chk($sformatf("a_beat%0d_valid", j), vld_a, 1);
      chk($sformatf("a_beat%0d_data", j), dat_a, (j % 4) * 1024 + j / 4);
      chk($sformatf("a_beat%0d_chan", j), ch_a, j % 4);
      chk($sformatf("a_beat%0d_last", j), last_a, 0);
    end

    rdy_a = 0;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("stall_valid", vld_a, 1);
      chk("stall_data", dat_a, 3073);
      chk("stall_chan", ch_a, 3);
    end
    rst_n = 1'b0;
    #1;
    chk("midstall_rst_valid", vld_a, 0);
    chk("midstall_rst_data", dat_a, 0);
    chk("midstall_rst_chan", ch_a, 0);
    chk("midstall_rst_last", last_a, 0);
    tick();
    rst_n = 1'b1; rdy_a = 1;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk($sformatf("post_rst_acc%0d", j), dat_a, j * 1024);
    end

    rst_n = 1'b0; step_a = 10000; mode_a = 0;
    tick();
    rst_n = 1'b1;
    for (int j = 0; j < 32; j++) begin
      tick();
      chk($sformatf("frame_beat%0d_data", j), dat_a, fr_exp[j]);
      chk($sformatf("frame_beat%0d_chan", j), ch_a, j % 4);
      chk($sformatf("frame_beat%0d_last", j), last_a, (j % 16) == 15);
      if (j == 5) mode_a = 1;
    end

    tick();
    chk("beat32_data", dat_a, 30000);
    rdy_a = 0; en_a = 0;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("stop_stall_valid", vld_a, 1);
      chk("stop_stall_data", dat_a, 30000);
    end
    rdy_a = 1;
    tick();
    chk("stop_after_xfer_valid", vld_a, 0);
    tick();
    chk("stop_idle_valid", vld_a, 0);

    en_a = 1;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk($sformatf("resume%0d_data", j), dat_a, resume_exp[j]);
      chk($sformatf("resume%0d_chan", j), ch_a, j);
      chk($sformatf("resume%0d_last", j), last_a, 0);
    end
    en_a = 0;
    tick();
    chk("stop2_valid", vld_a, 0);
    mode_a = 2; en_a = 1;
    for (int j = 0; j < 5; j++) begin
      tick();
      chk($sformatf("const%0d_data", j), dat_a, (j % 4) * 1024);
    end

    rst_n = 1'b0; mode_a = 3; step_a = 1;
    tick();
    rst_n = 1'b1;
    tick();
    chk("seq_first_data", dat_a, 0);
    chk("seq_first_chan", ch_a, 0);
    exp_seq = 0; exp_ch = 0; exp_set = 0; n_xfer = 0;
    bad_seq = 0; bad_stall = 0; bad_vld = 0;
    for (int i = 0; i < 10000; i++) begin
      rdy_a = ($urandom_range(0, 3) != 0);
      xfer = vld_a && rdy_a;
      p_dat = dat_a; p_ch = ch_a; p_last = last_a;
      tick();
      if (xfer) begin
        n_xfer++;
        if (exp_ch == 3) exp_set = (exp_set + 1) % 4;
        exp_ch = (exp_ch + 1) % 4;
        exp_seq = (exp_seq + 1) % 65536;
        if (dat_a !== 16'(exp_seq) || ch_a !== 2'(exp_ch) ||
            last_a !== (exp_ch == 3 && exp_set == 3)) bad_seq++;
      end else if (dat_a !== p_dat || ch_a !== p_ch || last_a !== p_last) begin
        bad_stall++;
      end
      if (vld_a !== 1'b1) bad_vld++;
    end
    chk("bp_seq_errors", bad_seq, 0);
    chk("bp_stall_errors", bad_stall, 0);
    chk("bp_valid_drops", bad_vld, 0);
    chk("bp_progress", n_xfer > 5000, 1);
    en_a = 0; rdy_a = 1;

    en_b = 1; mode_b = 1; step_b = 10000; rdy_b = 1;
    for (int j = 0; j < 10; j++) begin
      tick();
      chk($sformatf("b_beat%0d_data", j), dat_b, bt_exp[j]);
      if (j >= 3) begin
        mode_b = 0; step_b = 20000;
      end
    end
    en_b = 0;

    en_c = 1; mode_c = 0; step_c = 1; rdy_c = 1;
    for (int j = 0; j < 22; j++) begin
      tick();
      chk($sformatf("c_tri%0d_data", j), dat_c, (j <= 10) ? j : ((j <= 20) ? 20 - j : j - 20));
    end
    chk("c_last_single", last_c, 1);
    step_c = 0;
    for (int j = 22; j < 25; j++) begin
      tick();
      chk($sformatf("c_step0_%0d_data", j), dat_c, 2);
    end
    mode_c = 3;
    tick();
    chk("c_seq_first", dat_c, 25);
    exp_seq = 25; bad_seq = 0; bad_stall = 0; saw_wrap = 0;
    for (int i = 0; i < 700; i++) begin
      rdy_c = ($urandom_range(0, 3) != 0);
      xfer = vld_c && rdy_c;
      p_dat = 16'(dat_c);
      tick();
      if (xfer) begin
        exp_seq = (exp_seq + 1) % 256;
        if (dat_c !== 8'(exp_seq)) bad_seq++;
        if (p_dat == 16'd255 && dat_c == 8'd0) saw_wrap = 1;
      end else if (16'(dat_c) !== p_dat) begin
        bad_stall++;
      end
    end
    chk("c_seq_errors", bad_seq, 0);
    chk("c_stall_errors", bad_stall, 0);
    chk("c_seq_wrapped", saw_wrap, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
